circuito_exibe_sequencia: RTL

CIRCUITO_EXIBE_SEQUENCIA -- requirements
Module: circuito_exibe_sequencia

---
 rtl/circuito_exibe_sequencia_pkg.sv | 20 ++
 rtl/circuito_exibe_sequencia_fd.sv | 83 ++++++++
 rtl/circuito_exibe_sequencia_uc.sv | 92 +++++++++
 rtl/contador_m.sv | 25 ++
 rtl/circuito_exibe_sequencia.sv | 62 ++++++
 5 files changed

// File: rtl/circuito_exibe_sequencia_pkg.sv
// Shared definitions for the sequence display block and its sibling circuito_exp4:
// control state encodings and default presentation timing.
package circuito_exibe_sequencia_pkg;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam int TEMPO_ACESO_PADRAO   = 500;
    localparam int TEMPO_APAGADO_PADRAO = 250;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/circuito_exibe_sequencia_fd.sv
// Datapath: interval timer, ROM address counter, captured limit and the registered leds.
module circuito_exibe_sequencia_fd
    import circuito_exibe_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
    parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera_timer,
    input  logic       conta_timer,
    input  logic       zera_end,
    input  logic       conta_end,
    input  logic       zera_leds,
    input  logic       carrega_leds,
    input  logic       registra_limite,
    input  logic [3:0] limite,
    input  logic [3:0] dado_rom,
    output logic       fim_aceso,
    output logic       fim_apagado,
    output logic       ultimo,
    output logic [3:0] endereco,
    output logic [3:0] leds
);
    localparam int TM = max_int(TEMPO_ACESO, TEMPO_APAGADO);
    localparam int TW = (TM < 2) ? 1 : $clog2(TM + 1);

    logic [TW-1:0] timer_q;
    logic          timer_fim;
    logic [3:0]    end_q;
    logic          end_fim;
    logic          avanca;
    logic [3:0]    limite_reg;
    logic [3:0]    leds_reg;

    contador_m #(.M(TM), .N(TW)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .q     (timer_q),
        .fim   (timer_fim)
    );

    // The counter's own terminal flag covers whichever interval is the longer one.
    assign fim_aceso   = (TEMPO_ACESO == TM)   ? timer_fim : (timer_q == TW'(TEMPO_ACESO - 1));
    assign fim_apagado = (TEMPO_APAGADO == TM) ? timer_fim : (timer_q == TW'(TEMPO_APAGADO - 1));

    assign avanca = conta_end & ~end_fim;

    contador_m #(.M(16), .N(4)) u_endereco (
        .clock (clock),
        .reset (reset),
        .zera  (zera_end),
        .conta (avanca),
        .q     (end_q),
        .fim   (end_fim)
    );

    // While stepping, the ROM is already addressed at the next item so leds load
    // the new item on the same edge the counter advances.
    assign endereco = avanca ? end_q + 4'd1 : end_q;
    assign ultimo   = (end_q == limite_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            limite_reg <= '0;
            leds_reg   <= '0;
        end else begin
            if (registra_limite) begin
                limite_reg <= limite;
            end
            if (zera_leds) begin
                leds_reg <= '0;
            end else if (carrega_leds) begin
                leds_reg <= dado_rom;
            end
        end
    end

    assign leds = leds_reg;

endmodule

// File: rtl/circuito_exibe_sequencia_uc.sv
// Control FSM sequencing one presentation round over the datapath.
module circuito_exibe_sequencia_uc
    import circuito_exibe_sequencia_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic iniciar,
    input  logic fim_aceso,
    input  logic fim_apagado,
    input  logic ultimo,
    output logic zera_timer,
    output logic conta_timer,
    output logic zera_end,
    output logic conta_end,
    output logic zera_leds,
    output logic carrega_leds,
    output logic registra_limite,
    output logic exibindo,
    output logic pronto
);
    estado_t estado_reg, estado_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next     = estado_reg;
        zera_timer      = 1'b0;
        conta_timer     = 1'b0;
        zera_end        = 1'b0;
        conta_end       = 1'b0;
        zera_leds       = 1'b0;
        carrega_leds    = 1'b0;
        registra_limite = 1'b0;
        exibindo        = 1'b0;
        pronto          = 1'b0;
        case (estado_reg)
            INICIAL: begin
                zera_timer = 1'b1;
                zera_end   = 1'b1;
                zera_leds  = 1'b1;
                if (iniciar) begin
                    registra_limite = 1'b1;
                    estado_next     = PREPARA;
                end
            end
            PREPARA: begin
                exibindo     = 1'b1;
                zera_timer   = 1'b1;
                zera_end     = 1'b1;
                carrega_leds = 1'b1;
                estado_next  = ACESO;
            end
            ACESO: begin
                exibindo    = 1'b1;
                conta_timer = 1'b1;
                if (fim_aceso) begin
                    zera_timer  = 1'b1;
                    zera_leds   = 1'b1;
                    estado_next = APAGADO;
                end
            end
            APAGADO: begin
                exibindo    = 1'b1;
                conta_timer = 1'b1;
                if (fim_apagado) begin
                    zera_timer = 1'b1;
                    if (ultimo) begin
                        estado_next = FIM;
                    end else begin
                        conta_end    = 1'b1;
                        carrega_leds = 1'b1;
                        estado_next  = ACESO;
                    end
                end
            end
            FIM: begin
                pronto      = 1'b1;
                zera_end    = 1'b1;
                zera_leds   = 1'b1;
                estado_next = INICIAL;
            end
            default: estado_next = INICIAL;
        endcase
    end

endmodule

// File: rtl/contador_m.sv
// Generic modulo-M counter with synchronous clear, count enable and terminal-count flag.
module contador_m #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] q,
    output logic         fim
);
    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + N'(1);
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/circuito_exibe_sequencia.sv
// Presents ROM items 0..limite on the leds, each lit then blanked for fixed intervals.
module circuito_exibe_sequencia
    import circuito_exibe_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
    parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_rom,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto
);
    logic zera_timer, conta_timer, zera_end, conta_end;
    logic zera_leds, carrega_leds, registra_limite;
    logic fim_aceso, fim_apagado, ultimo;

    circuito_exibe_sequencia_fd #(
        .TEMPO_ACESO   (TEMPO_ACESO),
        .TEMPO_APAGADO (TEMPO_APAGADO)
    ) u_fd (
        .clock           (clock),
        .reset           (reset),
        .zera_timer      (zera_timer),
        .conta_timer     (conta_timer),
        .zera_end        (zera_end),
        .conta_end       (conta_end),
        .zera_leds       (zera_leds),
        .carrega_leds    (carrega_leds),
        .registra_limite (registra_limite),
        .limite          (limite),
        .dado_rom        (dado_rom),
        .fim_aceso       (fim_aceso),
        .fim_apagado     (fim_apagado),
        .ultimo          (ultimo),
        .endereco        (endereco),
        .leds            (leds)
    );

    circuito_exibe_sequencia_uc u_uc (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .fim_aceso       (fim_aceso),
        .fim_apagado     (fim_apagado),
        .ultimo          (ultimo),
        .zera_timer      (zera_timer),
        .conta_timer     (conta_timer),
        .zera_end        (zera_end),
        .conta_end       (conta_end),
        .zera_leds       (zera_leds),
        .carrega_leds    (carrega_leds),
        .registra_limite (registra_limite),
        .exibindo        (exibindo),
        .pronto          (pronto)
    );

endmodule
